// File: rtl/lia_pkg.sv
// Shared widths, pipeline payload types and the output saturation helper
// for the dual-phase lock-in amplifier.
package lia_pkg;

  localparam int unsigned DW        = 14;
  localparam int unsigned WIN_LOG2  = 4;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned OUT_SHIFT = 24;
  localparam int unsigned PW        = 2 * DW;

  typedef logic signed [DW-1:0]    sample_t;
  typedef logic signed [PW-1:0]    product_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Stage-1 payload: ADC sample paired with its reference
  typedef struct packed {
    sample_t sig;
    sample_t lo;
  } mix_in_t;

  typedef enum logic [0:0] {
    WIN_IDLE = 1'b0,
    WIN_RUN  = 1'b1
  } win_state_t;

  localparam acc_t SAT_HI = acc_t'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam acc_t SAT_LO = acc_t'(-(64'sd1 <<< (DW - 1)));

  // Clamp an already-shifted integral into the signed DW-bit output range
  function automatic sample_t sat_dw(input acc_t v);
    sample_t r;
    if (v > SAT_HI) begin
      r = sample_t'(SAT_HI);
    end else if (v < SAT_LO) begin
      r = sample_t'(SAT_LO);
    end else begin
      r = sample_t'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/lia_channel.sv
// One lock-in arm: register inputs, multiply by the reference, integrate
// over the window, then dump the shifted and saturated integral.
module lia_channel
  import lia_pkg::*;
#(
  parameter int unsigned SHIFT = OUT_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sig,
  input  logic [DW-1:0] lo,
  input  logic          win_load,
  input  logic          win_acc,
  input  logic          win_dump,
  output logic [DW-1:0] result
);

  mix_in_t  s1_q;
  product_t prod_q;
  acc_t     acc_q;
  acc_t     hold_q;
  logic     dump_q;
  sample_t  result_q;

  acc_t prod_ext_c;
  acc_t shifted_c;

  assign prod_ext_c = acc_t'(prod_q);
  assign shifted_c  = hold_q >>> SHIFT;

  // win_load restarts the integral with the edge-cycle product; the old
  // total is parked in hold_q and saturated on the following clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      hold_q   <= '0;
      dump_q   <= 1'b0;
      result_q <= '0;
    end else begin
      s1_q.sig <= sample_t'(sig);
      s1_q.lo  <= sample_t'(lo);
      prod_q   <= product_t'(s1_q.sig) * product_t'(s1_q.lo);
      dump_q   <= win_dump;
      if (win_dump) begin
        hold_q <= acc_q;
      end
      if (win_load) begin
        acc_q <= prod_ext_c;
      end else if (win_acc) begin
        acc_q <= acc_q + prod_ext_c;
      end
      if (dump_q) begin
        result_q <= sat_dw(shifted_c);
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/lock_in_amplifier.sv
// Dual-phase lock-in amplifier: shared sync-edge detect and window control
// driving identical I and Q channels, plus a free-running debug ramp.
module lock_in_amplifier
  import lia_pkg::*;
#(
  parameter int unsigned SHIFT    = OUT_SHIFT,
  parameter int unsigned WIN_BITS = WIN_LOG2
) (
  input  logic          dac_clk_i,
  input  logic          dac_rstn_i,
  input  logic [DW-1:0] adcInputChannel1,
  input  logic [DW-1:0] inPhase,
  input  logic [DW-1:0] outPhase,
  input  logic          mhzClockIn,
  output logic [DW-1:0] LIAOutput_InPhaseOutput,
  output logic [DW-1:0] LIAOutput_OutPhaseOutput,
  output logic [DW-1:0] MiscRamp
);

  logic                sync_q;
  logic                sync_d_q;
  logic                edge_s2_q;
  logic [WIN_BITS-1:0] win_cnt_q;
  logic [DW-1:0]       ramp_q;
  win_state_t          state_q;
  win_state_t          state_c;

  logic edge_s1_c;
  logic last_c;
  logic win_load_c;
  logic win_acc_c;
  logic win_dump_c;

  // Edge flag travels one stage so it lines up with the product register
  assign edge_s1_c = sync_q & ~sync_d_q;
  assign last_c    = &win_cnt_q;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      sync_q    <= 1'b0;
      sync_d_q  <= 1'b0;
      edge_s2_q <= 1'b0;
      win_cnt_q <= '0;
      ramp_q    <= '0;
    end else begin
      sync_q    <= mhzClockIn;
      sync_d_q  <= sync_q;
      edge_s2_q <= edge_s1_c;
      ramp_q    <= ramp_q + DW'(1);
      if (edge_s2_q && (state_q == WIN_RUN)) begin
        win_cnt_q <= win_cnt_q + WIN_BITS'(1);
      end
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q <= WIN_IDLE;
    end else begin
      state_q <= state_c;
    end
  end

  // Window stays open forever once the first aligned edge arrives
  always_comb begin
    state_c = state_q;
    if ((state_q == WIN_IDLE) && edge_s2_q) begin
      state_c = WIN_RUN;
    end
  end

  always_comb begin
    win_load_c = 1'b0;
    win_acc_c  = 1'b0;
    win_dump_c = 1'b0;
    case (state_q)
      WIN_IDLE: begin
        win_load_c = edge_s2_q;
      end
      default: begin
        win_acc_c  = 1'b1;
        win_load_c = edge_s2_q & last_c;
        win_dump_c = edge_s2_q & last_c;
      end
    endcase
  end

  lia_channel #(
    .SHIFT(SHIFT)
  ) u_chan_i (
    .clk     (dac_clk_i),
    .rst_n   (dac_rstn_i),
    .sig     (adcInputChannel1),
    .lo      (inPhase),
    .win_load(win_load_c),
    .win_acc (win_acc_c),
    .win_dump(win_dump_c),
    .result  (LIAOutput_InPhaseOutput)
  );

  lia_channel #(
    .SHIFT(SHIFT)
  ) u_chan_q (
    .clk     (dac_clk_i),
    .rst_n   (dac_rstn_i),
    .sig     (adcInputChannel1),
    .lo      (outPhase),
    .win_load(win_load_c),
    .win_acc (win_acc_c),
    .win_dump(win_dump_c),
    .result  (LIAOutput_OutPhaseOutput)
  );

  assign MiscRamp = ramp_q;

endmodule

// File: tb/tb_lock_in_amplifier.sv
// Directed bench for the lock-in amplifier: default instance plus a
// second instance with a smaller output shift to reach saturation.
module tb_lock_in_amplifier;

  localparam int M_ZERO  = 0;
  localparam int M_DC    = 1;
  localparam int M_NEG   = 2;
  localparam int M_SAT   = 3;
  localparam int M_SIN_I = 4;
  localparam int M_SIN_Q = 5;
  localparam int M_IMP   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] adc;
  logic [13:0] ip;
  logic [13:0] op;
  logic        sync;
  logic [13:0] i_out, q_out, ramp;
  logic [13:0] i22, q22, ramp22;

  int checks = 0;
  int errors = 0;
  int phase;
  int tick_no;
  int mode;
  int imp_a;
  int imp_b;
  int sin_tab[125];
  int cos_tab[125];

  always #5 clk = ~clk;

  lock_in_amplifier dut (
    .dac_clk_i               (clk),
    .dac_rstn_i              (rst_n),
    .adcInputChannel1        (adc),
    .inPhase                 (ip),
    .outPhase                (op),
    .mhzClockIn              (sync),
    .LIAOutput_InPhaseOutput (i_out),
    .LIAOutput_OutPhaseOutput(q_out),
    .MiscRamp                (ramp)
  );

  lock_in_amplifier #(.SHIFT(22)) dut22 (
    .dac_clk_i               (clk),
    .dac_rstn_i              (rst_n),
    .adcInputChannel1        (adc),
    .inPhase                 (ip),
    .outPhase                (op),
    .mhzClockIn              (sync),
    .LIAOutput_InPhaseOutput (i22),
    .LIAOutput_OutPhaseOutput(q22),
    .MiscRamp                (ramp22)
  );

  // One sample period: sync pulses on phase 0 of every 125-clock period
  task automatic tick();
    int k;
    k = phase;
    @(posedge clk);
    #1;
    sync = (k == 0);
    case (mode)
      M_DC:    begin adc = 14'(4096);  ip = 14'(4096);  op = 14'(0);     end
      M_NEG:   begin adc = 14'(8191);  ip = 14'(-8192); op = 14'(0);     end
      M_SAT:   begin adc = 14'(-8192); ip = 14'(-8192); op = 14'(-8192); end
      M_SIN_I: begin adc = 14'(sin_tab[k]); ip = 14'(sin_tab[k]); op = 14'(cos_tab[k]); end
      M_SIN_Q: begin adc = 14'(cos_tab[k]); ip = 14'(sin_tab[k]); op = 14'(cos_tab[k]); end
      M_IMP: begin
        adc = ((tick_no == imp_a) || (tick_no == imp_b)) ? 14'(8191) : 14'(0);
        ip  = 14'(8191);
        op  = 14'(-8191);
      end
      default: begin adc = 14'(0); ip = 14'(0); op = 14'(0); end
    endcase
    phase   = (phase == 124) ? 0 : phase + 1;
    tick_no = tick_no + 1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sync  = 1'b0;
    adc   = '0;
    ip    = '0;
    op    = '0;
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    phase   = 0;
    tick_no = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (i_out !== 14'(0)) begin errors++; $display("FAIL rst_i got %0d want 0", $signed(i_out)); end
    checks++; if (q_out !== 14'(0)) begin errors++; $display("FAIL rst_q got %0d want 0", $signed(q_out)); end
    checks++; if (ramp !== 14'(0)) begin errors++; $display("FAIL rst_ramp got %0d want 0", ramp); end
    mode = M_DC;
    run(2010);
    checks++; if (i_out !== 14'(2000)) begin errors++; $display("FAIL pre_rst_i got %0d want 2000", $signed(i_out)); end
    run(990);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (i_out !== 14'(0)) begin errors++; $display("FAIL async_rst_i got %0d want 0", $signed(i_out)); end
    checks++; if (q_out !== 14'(0)) begin errors++; $display("FAIL async_rst_q got %0d want 0", $signed(q_out)); end
    checks++; if (ramp !== 14'(0)) begin errors++; $display("FAIL async_rst_ramp got %0d want 0", ramp); end
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    phase   = 0;
    tick_no = 0;
    run(2000);
    checks++; if (i_out !== 14'(0)) begin errors++; $display("FAIL post_rst_hold_i got %0d want 0", $signed(i_out)); end
    run(10);
    checks++; if (i_out !== 14'(2000)) begin errors++; $display("FAIL post_rst_i got %0d want 2000", $signed(i_out)); end
  endtask

  task automatic test_dc();
    do_reset();
    mode = M_DC;
    run(2001);
    run(3);
    checks++; if (i_out !== 14'(0)) begin errors++; $display("FAIL dc_latency_early got %0d want 0", $signed(i_out)); end
    run(1);
    checks++; if (i_out !== 14'(2000)) begin errors++; $display("FAIL dc_latency_i got %0d want 2000", $signed(i_out)); end
    checks++; if (q_out !== 14'(0)) begin errors++; $display("FAIL dc_q got %0d want 0", $signed(q_out)); end
    run(2010);
    checks++; if (i_out !== 14'(2000)) begin errors++; $display("FAIL dc_win2_i got %0d want 2000", $signed(i_out)); end
  endtask

  task automatic test_negative();
    do_reset();
    mode = M_NEG;
    run(2010);
    checks++; if (i_out !== 14'(-8000)) begin errors++; $display("FAIL neg_i got %0d want -8000", $signed(i_out)); end
    checks++; if (q_out !== 14'(0)) begin errors++; $display("FAIL neg_q got %0d want 0", $signed(q_out)); end
    checks++; if (i22 !== 14'(-8192)) begin errors++; $display("FAIL neg_sat_i22 got %0d want -8192", $signed(i22)); end
    do_reset();
    mode = M_SAT;
    run(2010);
    checks++; if (i_out !== 14'(8000)) begin errors++; $display("FAIL sat_i got %0d want 8000", $signed(i_out)); end
    checks++; if (i22 !== 14'(8191)) begin errors++; $display("FAIL sat_i22 got %0d want 8191", $signed(i22)); end
    checks++; if (q22 !== 14'(8191)) begin errors++; $display("FAIL sat_q22 got %0d want 8191", $signed(q22)); end
  endtask

  task automatic test_quadrature();
    int iv;
    int qv;
    do_reset();
    mode = M_SIN_I;
    run(2010);
    iv = $signed(i_out);
    qv = $signed(q_out);
    checks++; if (!(iv > 1000 && iv <= 4010)) begin errors++; $display("FAIL quad_i got %0d want 1001..4010", iv); end
    checks++; if (qv > 4 || qv < -4) begin errors++; $display("FAIL quad_q got %0d want -4..4", qv); end
    do_reset();
    mode = M_SIN_Q;
    run(2010);
    iv = $signed(i_out);
    qv = $signed(q_out);
    checks++; if (!(qv > 1000 && qv <= 4010)) begin errors++; $display("FAIL swap_q got %0d want 1001..4010", qv); end
    checks++; if (iv > 4 || iv < -4) begin errors++; $display("FAIL swap_i got %0d want -4..4", iv); end
  endtask

  // Impulses on the last sample of window 1 and on the closing-edge sample
  task automatic test_window_boundary();
    do_reset();
    mode  = M_IMP;
    imp_a = 1999;
    imp_b = 2000;
    run(2010);
    checks++; if (i_out !== 14'(3)) begin errors++; $display("FAIL bnd_w1_i got %0d want 3", $signed(i_out)); end
    checks++; if (q_out !== 14'(-4)) begin errors++; $display("FAIL bnd_w1_q got %0d want -4", $signed(q_out)); end
    run(2000);
    checks++; if (i_out !== 14'(3)) begin errors++; $display("FAIL bnd_w2_i got %0d want 3", $signed(i_out)); end
    checks++; if (q_out !== 14'(-4)) begin errors++; $display("FAIL bnd_w2_q got %0d want -4", $signed(q_out)); end
    run(2000);
    checks++; if (i_out !== 14'(0)) begin errors++; $display("FAIL bnd_w3_i got %0d want 0", $signed(i_out)); end
  endtask

  task automatic test_ramp();
    mode = M_ZERO;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ramp !== 14'(5)) begin errors++; $display("FAIL ramp_5 got %0d want 5", ramp); end
    repeat (16378) @(posedge clk);
    #1;
    checks++; if (ramp !== 14'(16383)) begin errors++; $display("FAIL ramp_max got %0d want 16383", ramp); end
    @(posedge clk);
    #1;
    checks++; if (ramp !== 14'(0)) begin errors++; $display("FAIL ramp_wrap got %0d want 0", ramp); end
    @(posedge clk);
    #1;
    checks++; if (ramp !== 14'(1)) begin errors++; $display("FAIL ramp_after_wrap got %0d want 1", ramp); end
  endtask

  initial begin
    real ang;
    rst_n   = 1'b0;
    sync    = 1'b0;
    adc     = '0;
    ip      = '0;
    op      = '0;
    mode    = M_ZERO;
    phase   = 0;
    tick_no = 0;
    imp_a   = -1;
    imp_b   = -1;
    for (int k = 0; k < 125; k++) begin
      ang        = 2.0 * 3.14159265358979 * k / 125.0;
      sin_tab[k] = $rtoi($floor(8191.0 * $sin(ang) + 0.5));
      cos_tab[k] = $rtoi($floor(8191.0 * $cos(ang) + 0.5));
    end
    test_reset();
    test_dc();
    test_negative();
    test_quadrature();
    test_window_boundary();
    test_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
